bka16_share_ctrl: RTL and testbench
===================================

# bka16_share_ctrl

Sequencing controller and round-robin arbiter that shares a single 16-bit no-carry-in Brent-Kung adder (`bka16_nocin`, instantiated internally) between two requesters. It supports native 16-bit adds and 32-bit adds. A 32-bit add runs as multiple passes through the one adder: low half, high half, then an optional carry-increment pass. Results return on a single valid/ready response port tagged with the requester ID.

## Interface
- No parameters; the datapath width is fixed by the 16-bit adder.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request valid
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready
- req0_wide / req1_wide  in  1  1 = 32-bit add, 0 = 16-bit add (bits [31:16] ignored)
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of the response
- rsp_sum  out  32  sum; [31:16] = 0 for 16-bit adds
- rsp_cout  out  1  carry out of the MSB of the selected width

## Operation
- States: IDLE, LO, HI, INC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant is combinational from the valids plus a 1-bit round-robin pointer `rr` (reset 0).
  - Only one requester valid: it wins.
  - Both valid: requester `rr` wins.
  - reqN_ready = (state == IDLE) & grantN. It is never high outside IDLE or for the loser.
  - On accept:
    - Capture operands, the wide flag and the ID into internal registers.
    - Set rr = ~winner.
    - Go to LO.
  - Requesters need not hold operands after accept.
- **LO**
  - Adder inputs are a[15:0] and b[15:0].
  - Register sum[15:0] and c_lo.
  - Narrow request: sum[31:16] = 0, cout = c_lo, go to RESP.
  - Wide request: go to HI.
- **HI**
  - Adder inputs are a[31:16] and b[31:16].
  - Register sum[31:16] and c_hi.
  - c_lo = 0: cout = c_hi, go to RESP.
  - c_lo = 1: go to INC.
- **INC**
  - Adder inputs are sum[31:16] and 16'h0001.
  - Register sum[31:16].
  - cout = c_hi | c_inc. The two carries are never both 1; the OR is still required.
  - Go to RESP.
- **RESP**
  - rsp_valid = 1.
  - rsp_sum, rsp_cout and rsp_id are registered and stable while waiting.
  - When rsp_valid & rsp_ready: go to IDLE.
- The adder is used by exactly one pass per cycle. Its input mux is selected by state; inputs are 0 in IDLE and RESP.
- All arithmetic is modulo 2^16 per pass. Wide results are modulo 2^32 with cout = bit 32.

## Timing
- Accept in cycle T, meaning a valid&ready edge at T.
- Earliest rsp_valid:
  - narrow at T+2;
  - wide with c_lo = 0 at T+3;
  - wide with c_lo = 1 at T+4.
- The next accept is possible in the cycle after the response handshake, since IDLE is re-entered. Peak throughput is one narrow add per 3 cycles.
- Backpressure: with rsp_ready low, RESP holds indefinitely, outputs are unchanged and both reqN_ready stay 0.
- A response handshake and a new request arriving in the same cycle: the new request is not accepted until the next cycle (IDLE).
- Reset values: rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, req0_ready = req1_ready = 0 while rst is high, rr = 0, all operand registers = 0.
- Reset asserted mid-operation:
  - Return to IDLE immediately.
  - The in-flight transaction is dropped with no response.
  - rsp_valid drops asynchronously.

## Test plan
- **Narrow add.** req0: wide = 0, a = 0x0000FFFF, b = 0x00000001, accepted at T. Expect rsp_valid at T+2 with rsp_sum = 0x00000000, rsp_cout = 1, rsp_id = 0.
- **Wide add, internal carry.** req1: wide = 1, a = 0x0000FFFF, b = 0x00000001. Expect rsp_valid at T+4, rsp_sum = 0x00010000, rsp_cout = 0, rsp_id = 1. Wide add 0x12340001 + 0x11110002 expects rsp_valid at T+3, rsp_sum = 0x23450003, rsp_cout = 0.
- **Wide overflow through INC.** a = 0xFFFFFFFF, b = 0x00000001. Expect rsp_sum = 0x00000000, rsp_cout = 1 at T+4. Also a = 0x80000000, b = 0x80000000: expect rsp_sum = 0x00000000, rsp_cout = 1 at T+3.
- **Arbitration.** Hold req0_valid and req1_valid continuously after reset. Expect grants in the order 0, 1, 0, 1, with exactly one ready per accept and rsp_id matching.
- **Backpressure.** Hold rsp_ready = 0 for 10 cycles after rsp_valid. Expect outputs stable, reqN_ready = 0 throughout, and the handshake completing on the first cycle rsp_ready = 1.
- **Reset mid-operation.** Pulse rst while in HI of a wide add. Expect rsp_valid = 0, all outputs at reset values, no response for the dropped request, and a following narrow add completing normally at T+2.

Source files
------------

// File: rtl/bka16_share_ctrl.sv
// Two-requester controller that time-shares one 16-bit Brent-Kung adder.
// 32-bit adds run as low pass, high pass and, when needed, a carry-increment pass.
module bka16_nocin (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);
  // Row 0 holds bit generate/propagate. Rows 1-4 are the up-sweep (span 1,2,4,8).
  // Rows 5-7 are the down-sweep (span 4,2,1), which fills in the remaining prefixes.
  logic [7:0][15:0] g, p;

  assign g[0] = a_i & b_i;
  assign p[0] = a_i ^ b_i;

  for (genvar l = 1; l < 8; l++) begin : g_lvl
    localparam int D = (l <= 4) ? (1 << (l - 1)) : (1 << (7 - l));
    for (genvar i = 0; i < 16; i++) begin : g_bit
      localparam bit UP = (l <= 4) && (((i + 1) % (2 * D)) == 0);
      localparam bit DN = (l > 4) && (((i + 1) % (2 * D)) == D) && (i >= 2 * D);
      if (UP || DN) begin : g_op
        assign g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i-D]);
        assign p[l][i] = p[l-1][i] & p[l-1][i-D];
      end else begin : g_pass
        assign g[l][i] = g[l-1][i];
        assign p[l][i] = p[l-1][i];
      end
    end
  end

  assign sum_o  = p[0] ^ {g[7][14:0], 1'b0};
  assign cout_o = g[7][15];
endmodule

module bka16_share_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_wide,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_wide,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout
);
  typedef enum logic [2:0] {IDLE, LO, HI, INC, RESP} state_e;

  state_e      state_q;
  logic        rr_q, wide_q, id_q, clo_q, chi_q, cout_q;
  logic [31:0] a_q, b_q, sum_q;

  logic        gnt0, gnt1;
  logic [15:0] add_a, add_b, add_s;
  logic        add_c;

  assign gnt0 = req0_valid & (~req1_valid | ~rr_q);
  assign gnt1 = req1_valid & (~req0_valid |  rr_q);

  // Gated by rst so nothing is offered while reset is held, even though the state sits in IDLE.
  assign req0_ready = (state_q == IDLE) & gnt0 & ~rst;
  assign req1_ready = (state_q == IDLE) & gnt1 & ~rst;

  always_comb begin
    add_a = 16'h0;
    add_b = 16'h0;
    case (state_q)
      LO:      begin add_a = a_q[15:0];    add_b = b_q[15:0];  end
      HI:      begin add_a = a_q[31:16];   add_b = b_q[31:16]; end
      INC:     begin add_a = sum_q[31:16]; add_b = 16'h0001;   end
      default: ;
    endcase
  end

  bka16_nocin u_add (.a_i(add_a), .b_i(add_b), .sum_o(add_s), .cout_o(add_c));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      wide_q  <= 1'b0;
      id_q    <= 1'b0;
      clo_q   <= 1'b0;
      chi_q   <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt0 | gnt1) begin
          a_q     <= gnt1 ? req1_a : req0_a;
          b_q     <= gnt1 ? req1_b : req0_b;
          wide_q  <= gnt1 ? req1_wide : req0_wide;
          id_q    <= gnt1;
          rr_q    <= ~gnt1;
          state_q <= LO;
        end
        LO: begin
          sum_q[15:0] <= add_s;
          clo_q       <= add_c;
          if (wide_q) state_q <= HI;
          else begin
            sum_q[31:16] <= 16'h0;
            cout_q       <= add_c;
            state_q      <= RESP;
          end
        end
        HI: begin
          sum_q[31:16] <= add_s;
          chi_q        <= add_c;
          if (clo_q) state_q <= INC;
          else begin
            cout_q  <= add_c;
            state_q <= RESP;
          end
        end
        INC: begin
          sum_q[31:16] <= add_s;
          cout_q       <= chi_q | add_c;
          state_q      <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_bka16_share_ctrl.sv
// Directed bench for bka16_share_ctrl.
// A cycle-level transaction model runs alongside the literal per-test expectations.
module tb_bka16_share_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 0, req0_ready, req0_wide = 0;
  logic [31:0] req0_a = 0, req0_b = 0;
  logic        req1_valid = 0, req1_ready, req1_wide = 0;
  logic [31:0] req1_a = 0, req1_b = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_id, rsp_cout;
  logic [31:0] rsp_sum;

  int checks = 0, failures = 0;

  bka16_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wide(req0_wide),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wide(req1_wide),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction. Its latency counts edges from accept to the visible response.
  bit          m_busy = 0, m_rr = 0, m_id, m_cout, m_g0, m_g1, m_ev;
  int          m_n, m_lat;
  logic [31:0] m_sum, m_a, m_b;
  logic [16:0] m_lo;
  logic [32:0] m_full;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_rr   = 0;
      chk("reset_outputs", {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_cout, rsp_sum},
          {5'b0, 32'h0});
    end else begin
      if (m_busy) m_n++;
      m_g0 = !m_busy && req0_valid && (!req1_valid || !m_rr);
      m_g1 = !m_busy && req1_valid && (!req0_valid ||  m_rr);
      chk("model_ready", {req0_ready, req1_ready}, {m_g0, m_g1});
      m_ev = m_busy && (m_n >= m_lat);
      chk("model_rsp_valid", rsp_valid, m_ev);
      if (m_ev && rsp_valid)
        chk("model_rsp_data", {rsp_id, rsp_cout, rsp_sum}, {m_id, m_cout, m_sum});
      if (m_ev && rsp_ready) m_busy = 0;
      else if (m_g0 || m_g1) begin
        m_a    = m_g1 ? req1_a : req0_a;
        m_b    = m_g1 ? req1_b : req0_b;
        m_lo   = {1'b0, m_a[15:0]} + {1'b0, m_b[15:0]};
        m_full = {1'b0, m_a} + {1'b0, m_b};
        if (m_g1 ? req1_wide : req0_wide) begin
          m_sum  = m_full[31:0];
          m_cout = m_full[32];
          m_lat  = m_lo[16] ? 4 : 3;
        end else begin
          m_sum  = {16'h0, m_lo[15:0]};
          m_cout = m_lo[16];
          m_lat  = 2;
        end
        m_id   = m_g1;
        m_rr   = !m_g1;
        m_busy = 1;
        m_n    = 0;
      end
    end
  end

  task automatic drive(input logic id, input logic wide, input logic [31:0] a, input logic [31:0] b);
    if (id) begin req1_valid = 1; req1_wide = wide; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_wide = wide; req0_a = a; req0_b = b; end
  endtask

  task automatic run_one(input string nm, input logic id, input logic wide,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] esum, input logic ecout, input int elat);
    bit got;
    int n;
    @(posedge clk); #1;
    drive(id, wide, a, b);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
    end
    chk({nm, "_accept"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    got = 0; n = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; n = k; end
    end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_rsp"}, {rsp_id, rsp_cout, rsp_sum}, {id, ecout, esum});
  endtask

  logic [31:0] hold_sum;
  bit          got;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;

    run_one("narrow_ffff_1",  0, 0, 32'h0000FFFF, 32'h00000001, 32'h00000000, 1, 2);
    run_one("wide_intcarry",  1, 1, 32'h0000FFFF, 32'h00000001, 32'h00010000, 0, 4);
    run_one("wide_nocarry",   0, 1, 32'h12340001, 32'h11110002, 32'h23450003, 0, 3);
    run_one("wide_ovf_inc",   1, 1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 4);
    run_one("wide_ovf_hi",    0, 1, 32'h80000000, 32'h80000000, 32'h00000000, 1, 3);
    run_one("narrow_hi_ign",  1, 0, 32'hABCD1234, 32'h55550001, 32'h00001235, 0, 2);

    // Arbitration: both held valid right after reset
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    drive(0, 0, 32'd1, 32'd2);
    drive(1, 0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1;
      end
      chk("arb_grant", {got, req0_ready, req1_ready}, (i % 2) ? 3'b101 : 3'b110);
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (rsp_valid) got = 1;
      end
      chk("arb_rsp", {got, rsp_id, rsp_sum}, {1'b1, (i % 2) ? 33'h1_00000007 : 33'h0_00000003});
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;

    // Backpressure: req0 wins (rr points at 0), req1 stays valid throughout
    rsp_ready = 0;
    drive(0, 0, 32'd5, 32'd6);
    drive(1, 0, 32'd3, 32'd4);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
    end
    chk("bp_accept", got, 1);
    @(posedge clk); #1 req0_valid = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    hold_sum = rsp_sum;
    chk("bp_first", {got, rsp_id, rsp_cout, hold_sum}, {3'b100, 32'h0000000B});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready},
          {3'b100, 32'h0000000B, 2'b00});
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1);
    @(negedge clk);
    chk("bp_done_next_accept", {rsp_valid, req1_ready}, 2'b01);
    @(posedge clk); #1 req1_valid = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    chk("bp_followup", {got, rsp_id, rsp_sum}, {2'b11, 32'h00000007});

    // Reset during the HI pass of a wide add that would need INC
    @(posedge clk); #1;
    drive(1, 1, 32'h0000FFFF, 32'h00000001);
    @(negedge clk);
    chk("rst_accept", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rst_mid_outputs", {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_cout, rsp_sum},
        {5'b0, 32'h0});
    @(posedge clk); #1 rst = 0;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    chk("rst_no_response", got, 0);
    run_one("post_rst_narrow", 0, 0, 32'h00000010, 32'h00000020, 32'h00000030, 0, 2);

    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
